// File: rtl/hdp_pkg.sv
// Shared HDP receiver definitions: default frame timing, FSM states and
// the widths used to compute the expected valid/update strobes.
package hdp_pkg;

  localparam int unsigned DEF_PACKETS_PER_LINE = 40;
  localparam int unsigned DEF_LINE_CLOCKS      = 44;
  localparam int unsigned DEF_LINES            = 1280;
  localparam int unsigned DEF_BACK_PORCH       = 24;
  localparam int unsigned DEF_UPDATE_PACKETS   = 28;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned PKT_IDX_W   = 6;
  localparam int unsigned LINE_IDX_W  = 11;
  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned ERR_CNT_W   = 8;
  localparam int unsigned POS_W       = 16;  // packet / line position counters
  localparam int unsigned K_W         = 32;  // flattened frame clock for update compare

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEEK   = 2'd1,
    ACTIVE = 2'd2,
    PORCH  = 2'd3
  } hdpState_e;

  // update is expected for the first updatePackets clocks of the frame
  function automatic logic expectUpdate(input logic [POS_W-1:0] line,
                                        input logic [POS_W-1:0] packet,
                                        input int unsigned lineClocks,
                                        input int unsigned updatePackets);
    logic [K_W-1:0] k;
    k = K_W'(line) * K_W'(lineClocks) + K_W'(packet);
    return k < K_W'(updatePackets);
  endfunction

endpackage

// File: rtl/hdp_timing_counter.sv
// Frame position counter: packet (p) and line within a frame, with the
// porch flag while past the last line and a flag on the last porch clock.
module hdp_timing_counter
  import hdp_pkg::*;
#(
  parameter int unsigned LINE_CLOCKS = DEF_LINE_CLOCKS,
  parameter int unsigned LINES       = DEF_LINES,
  parameter int unsigned BACK_PORCH  = DEF_BACK_PORCH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [POS_W-1:0] packet,
  output logic [POS_W-1:0] line,
  output logic             porch,
  output logic             frameEnd
);

  logic [POS_W-1:0] nextPacket;
  logic [POS_W-1:0] nextLine;

  // next position; during the porch line==LINES and packet counts porch clocks
  always_comb begin
    nextPacket = packet;
    nextLine   = line;
    if (clear) begin
      nextPacket = '0;
      nextLine   = '0;
    end else if (advance) begin
      if (porch) begin
        if (packet == POS_W'(BACK_PORCH - 1)) begin
          nextPacket = '0;
          nextLine   = '0;
        end else begin
          nextPacket = packet + POS_W'(1);
        end
      end else if (packet == POS_W'(LINE_CLOCKS - 1)) begin
        nextPacket = '0;
        nextLine   = line + POS_W'(1);
      end else begin
        nextPacket = packet + POS_W'(1);
      end
    end
  end

  // position registers and derived flags
  always_ff @(posedge clk) begin
    if (rst) begin
      packet   <= '0;
      line     <= '0;
      porch    <= 1'b0;
      frameEnd <= 1'b0;
    end else begin
      packet   <= nextPacket;
      line     <= nextLine;
      porch    <= (nextLine == POS_W'(LINES));
      frameEnd <= (nextLine == POS_W'(LINES)) && (nextPacket == POS_W'(BACK_PORCH - 1));
    end
  end

endmodule

// File: rtl/hdp_receiver.sv
// HDP panel receiver: locks onto the transmitter frame timing, forwards
// valid packets with their position and flags any timing mismatch.
// Optional per-frame packet sum enabled by HDP_RECEIVER_CHECKSUM_EN.
module hdp_receiver
  import hdp_pkg::*;
#(
  parameter int unsigned PACKETS_PER_LINE = DEF_PACKETS_PER_LINE,
  parameter int unsigned LINE_CLOCKS      = DEF_LINE_CLOCKS,
  parameter int unsigned LINES            = DEF_LINES,
  parameter int unsigned BACK_PORCH       = DEF_BACK_PORCH,
  parameter int unsigned UPDATE_PACKETS   = DEF_UPDATE_PACKETS
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_nReset,
  input  logic [DATA_W-1:0]      i_lcdData,
  input  logic                   i_valid,
  input  logic                   i_update,
  output logic [DATA_W-1:0]      o_pixelData,
  output logic                   o_pixelValid,
  output logic [PKT_IDX_W-1:0]   o_packetIndex,
  output logic [LINE_IDX_W-1:0]  o_lineIndex,
  output logic                   o_frameStart,
  output logic                   o_frameDone,
  output logic                   o_error,
  output logic                   o_locked,
  output logic [FRAME_CNT_W-1:0] o_frameCount,
  output logic [ERR_CNT_W-1:0]   o_errorCount,
  output logic [DATA_W-1:0]      o_checksum
);

  hdpState_e        state;
  logic             prevUpdate;
  logic [POS_W-1:0] packet;
  logic [POS_W-1:0] line;
  logic             porch;
  logic             frameEnd;

  logic expValid;
  logic expUpdate;
  logic mismatch;
  logic tracking;
  logic frameDetect;
  logic advance;
  logic accept;
  logic firstPacket;
  logic lastActive;
  logic frameDone;

  hdp_timing_counter #(
    .LINE_CLOCKS(LINE_CLOCKS),
    .LINES      (LINES),
    .BACK_PORCH (BACK_PORCH)
  ) u_timing (
    .clk     (i_clock),
    .rst     (i_reset),
    .clear   (!advance),
    .advance (advance),
    .packet  (packet),
    .line    (line),
    .porch   (porch),
    .frameEnd(frameEnd)
  );

  // expected strobes at the current frame clock and the resulting decisions
  always_comb begin
    expValid    = !porch && (packet < POS_W'(PACKETS_PER_LINE));
    expUpdate   = expectUpdate(line, packet, LINE_CLOCKS, UPDATE_PACKETS);
    mismatch    = (i_valid != expValid) || (i_update != expUpdate);
    tracking    = i_nReset && ((state == ACTIVE) || (state == PORCH));
    frameDetect = i_nReset && (state == SEEK) && i_update && i_valid && !prevUpdate;
    advance     = frameDetect || (tracking && !mismatch);
    accept      = advance && expValid;
    firstPacket = (packet == '0) && (line == '0);
    lastActive  = (line == POS_W'(LINES - 1)) && (packet == POS_W'(LINE_CLOCKS - 1));
    frameDone   = tracking && !mismatch && (state == PORCH) && frameEnd;
  end

  // previous update sample for rising-edge frame detection
  always_ff @(posedge i_clock) begin
    if (i_reset) prevUpdate <= 1'b0;
    else         prevUpdate <= i_update;
  end

  // receiver FSM with registered outputs
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      o_pixelData   <= '0;
      o_pixelValid  <= 1'b0;
      o_packetIndex <= '0;
      o_lineIndex   <= '0;
      o_frameStart  <= 1'b0;
      o_frameDone   <= 1'b0;
      o_error       <= 1'b0;
      o_locked      <= 1'b0;
      o_frameCount  <= '0;
      o_errorCount  <= '0;
    end else if (!i_nReset) begin
      state        <= IDLE;
      o_pixelValid <= 1'b0;
      o_frameStart <= 1'b0;
      o_frameDone  <= 1'b0;
      o_error      <= 1'b0;
      o_locked     <= 1'b0;
    end else begin
      o_pixelValid <= 1'b0;
      o_frameStart <= 1'b0;
      o_frameDone  <= 1'b0;
      o_error      <= 1'b0;

      if (accept) begin
        o_pixelValid  <= 1'b1;
        o_pixelData   <= i_lcdData;
        o_packetIndex <= PKT_IDX_W'(packet);
        o_lineIndex   <= LINE_IDX_W'(line);
        o_frameStart  <= firstPacket;
      end

      if (tracking && mismatch) begin
        state    <= SEEK;
        o_error  <= 1'b1;
        o_locked <= 1'b0;
        if (o_errorCount != '1) o_errorCount <= o_errorCount + ERR_CNT_W'(1);
      end else begin
        case (state)
          IDLE:   state <= SEEK;
          SEEK:   if (frameDetect) state <= ACTIVE;
          ACTIVE: if (lastActive) state <= PORCH;
          PORCH: begin
            if (frameDone) begin
              state        <= ACTIVE;
              o_frameDone  <= 1'b1;
              o_locked     <= 1'b1;
              o_frameCount <= o_frameCount + FRAME_CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef HDP_RECEIVER_CHECKSUM_EN
  logic [DATA_W-1:0] checksumAcc;

  // per-frame sum of accepted packets, published at frame done
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      checksumAcc <= '0;
      o_checksum  <= '0;
    end else begin
      if (accept) checksumAcc <= (firstPacket ? '0 : checksumAcc) + i_lcdData;
      if (frameDone) o_checksum <= checksumAcc;
    end
  end
`else
  assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_hdp_receiver.sv
// Self-checking bench for hdp_receiver with a reduced frame geometry.
// Honours HDP_RECEIVER_CHECKSUM_EN in the reference model.
module tb_hdp_receiver;

  localparam int PPL   = 6;
  localparam int LC    = 8;
  localparam int LINES = 10;
  localparam int BP    = 5;
  localparam int UP    = 11;  // spans into line 1
  localparam int TOTAL = LINES * LC + BP;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_nReset = 1'b0;
  logic [31:0] i_lcdData = '0;
  logic        i_valid = 1'b0;
  logic        i_update = 1'b0;
  logic [31:0] o_pixelData;
  logic        o_pixelValid;
  logic [5:0]  o_packetIndex;
  logic [10:0] o_lineIndex;
  logic        o_frameStart;
  logic        o_frameDone;
  logic        o_error;
  logic        o_locked;
  logic [15:0] o_frameCount;
  logic [7:0]  o_errorCount;
  logic [31:0] o_checksum;

  hdp_receiver #(
    .PACKETS_PER_LINE(PPL),
    .LINE_CLOCKS     (LC),
    .LINES           (LINES),
    .BACK_PORCH      (BP),
    .UPDATE_PACKETS  (UP)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_nReset     (i_nReset),
    .i_lcdData    (i_lcdData),
    .i_valid      (i_valid),
    .i_update     (i_update),
    .o_pixelData  (o_pixelData),
    .o_pixelValid (o_pixelValid),
    .o_packetIndex(o_packetIndex),
    .o_lineIndex  (o_lineIndex),
    .o_frameStart (o_frameStart),
    .o_frameDone  (o_frameDone),
    .o_error      (o_error),
    .o_locked     (o_locked),
    .o_frameCount (o_frameCount),
    .o_errorCount (o_errorCount),
    .o_checksum   (o_checksum)
  );

  always #5 i_clock = ~i_clock;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit          mIdle = 1'b1;
  bit          mTrack = 1'b0;
  int          mK = 0;
  bit          mPrevUpd = 1'b0;
  bit          mLocked = 1'b0;
  logic [15:0] mFrames = '0;
  logic [7:0]  mErrs = '0;
  logic [31:0] mChecksum = '0;
  logic [31:0] mAcc = '0;
  bit          eValid, eStart, eDone, eErr;
  logic [31:0] eData;
  int          ePkt, eLine;

  // observed event bookkeeping
  int edgeNum = 0;
  int startEdge = 0, doneEdge = 0, errEdge = 0;
  int nPix = 0, nStart = 0, nDone = 0, nErr = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clearCounts();
    nPix = 0; nStart = 0; nDone = 0; nErr = 0;
  endtask

  task automatic acceptPacket(input int k, input logic [31:0] d);
    eValid = 1'b1;
    eData  = d;
    ePkt   = k % LC;
    eLine  = k / LC;
    eStart = (k == 0);
`ifdef HDP_RECEIVER_CHECKSUM_EN
    mAcc = ((k == 0) ? 32'd0 : mAcc) + d;
`endif
  endtask

  // one clock: drive on the falling edge, predict, then check after the rising edge
  task automatic step(input bit rst, input bit nres, input bit v, input bit u, input logic [31:0] d);
    bit ev, eu;
    @(negedge i_clock);
    i_reset = rst; i_nReset = nres; i_valid = v; i_update = u; i_lcdData = d;
    @(posedge i_clock);
    eValid = 0; eStart = 0; eDone = 0; eErr = 0;
    if (rst) begin
      mIdle = 1; mTrack = 0; mK = 0; mLocked = 0;
      mFrames = '0; mErrs = '0; mChecksum = '0; mAcc = '0;
    end else if (!nres) begin
      mIdle = 1; mTrack = 0; mK = 0; mLocked = 0;
    end else if (mIdle) begin
      mIdle = 0;
    end else if (!mTrack) begin
      if (v && u && !mPrevUpd) begin
        acceptPacket(0, d);
        mTrack = 1; mK = 1;
      end
    end else begin
      ev = (mK < LINES * LC) && ((mK % LC) < PPL);
      eu = (mK < UP);
      if (v != ev || u != eu) begin
        eErr = 1; mLocked = 0; mTrack = 0; mK = 0;
        if (mErrs != 8'hFF) mErrs = mErrs + 8'd1;
      end else begin
        if (ev) acceptPacket(mK, d);
        if (mK == TOTAL - 1) begin
          eDone = 1; mLocked = 1; mFrames = mFrames + 16'd1; mK = 0;
`ifdef HDP_RECEIVER_CHECKSUM_EN
          mChecksum = mAcc;
`endif
        end else begin
          mK++;
        end
      end
    end
    mPrevUpd = rst ? 1'b0 : u;
    #1;
    check("status",
          64'({o_pixelValid, o_frameStart, o_frameDone, o_error, o_locked,
               o_frameCount, o_errorCount, o_checksum}),
          64'({eValid, eStart, eDone, eErr, mLocked, mFrames, mErrs, mChecksum}));
    if (eValid)
      check("packet", 64'({o_pixelData, o_packetIndex, o_lineIndex}),
            64'({eData, 6'(ePkt), 11'(eLine)}));
    edgeNum++;
    if (o_pixelValid) nPix++;
    if (o_frameStart) begin nStart++; startEdge = edgeNum; end
    if (o_frameDone)  begin nDone++;  doneEdge = edgeNum;  end
    if (o_error)      begin nErr++;   errEdge = edgeNum;   end
  endtask

  // transmitter model: one frame, optional valid glitch, dropped update or early stop
  task automatic sendFrame(input int glitchK, input bit noUpd, input bit ones, input int stopK);
    bit v, u;
    logic [31:0] d;
    for (int k = 0; k < TOTAL; k++) begin
      if (k == stopK) return;
      v = (k < LINES * LC) && ((k % LC) < PPL);
      u = noUpd ? 1'b0 : (k < UP);
      if (k == glitchK) v = 1'b1;
      d = ones ? 32'd1 : $urandom;
      step(0, 1, v, u, d);
    end
  endtask

  task automatic idleCycles(input bit nres);
    repeat ($urandom_range(2, 6)) step(0, nres, 1'b0, 1'b0, $urandom);
  endtask

  initial begin
    // reset state
    step(1, 0, 0, 0, 32'hDEADBEEF);
    step(1, 1, 1, 1, 32'hDEADBEEF);
    check("rst_data", 64'(o_pixelData), 64'd0);
    check("rst_index", 64'({o_packetIndex, o_lineIndex}), 64'd0);
    idleCycles(1);

    // clean frame
    clearCounts();
    sendFrame(-1, 0, 0, -1);
    check("clean_pixels", 64'(nPix), 64'(LINES * PPL));
    check("clean_length", 64'(doneEdge - startEdge), 64'(TOTAL - 1));
    check("clean_frames", 64'(o_frameCount), 64'd1);
    check("clean_locked", 64'(o_locked), 64'd1);

    // back-to-back frames
    clearCounts();
    repeat (3) sendFrame(-1, 0, 0, -1);
    check("b2b_frames", 64'(o_frameCount), 64'd4);
    check("b2b_errors", 64'(o_errorCount), 64'd0);
    check("b2b_starts", 64'(nStart), 64'd3);
    check("b2b_dones", 64'(nDone), 64'd3);

    // valid glitch in line blanking of line 5
    clearCounts();
    sendFrame(5 * LC + PPL + 1, 0, 0, -1);
    check("glitch_errors", 64'(nErr), 64'd1);
    check("glitch_when", 64'(errEdge - startEdge), 64'(5 * LC + PPL + 1));
    check("glitch_done", 64'(nDone), 64'd0);
    check("glitch_locked", 64'(o_locked), 64'd0);
    clearCounts();
    sendFrame(-1, 0, 0, -1);
    check("relock_start", 64'(nStart), 64'd1);
    check("relock_locked", 64'(o_locked), 64'd1);

    // missing update on the second frame of a fresh run
    step(1, 1, 0, 0, 32'd0);
    idleCycles(1);
    sendFrame(-1, 0, 0, -1);
    clearCounts();
    sendFrame(-1, 1, 0, -1);
    check("noupd_errcount", 64'(o_errorCount), 64'd1);
    check("noupd_starts", 64'(nStart), 64'd0);
    clearCounts();
    sendFrame(-1, 0, 0, -1);
    check("seek_relock", 64'({nStart[7:0], nDone[7:0]}), 64'h0101);

    // checksum over an all-ones frame
    sendFrame(-1, 0, 1, -1);
`ifdef HDP_RECEIVER_CHECKSUM_EN
    check("checksum", 64'(o_checksum), 64'(LINES * PPL));
`else
    check("checksum", 64'(o_checksum), 64'd0);
`endif

    // i_reset mid-frame
    sendFrame(-1, 0, 0, (LINES / 2 + 1) * LC);
    step(1, 1, 1, 0, $urandom);
    check("midrst_status", 64'({o_pixelValid, o_locked, o_frameCount, o_errorCount, o_checksum}), 64'd0);
    check("midrst_data", 64'({o_pixelData, o_packetIndex, o_lineIndex}), 64'd0);

    // i_nReset low mid-frame
    idleCycles(1);
    sendFrame(-1, 0, 0, -1);
    sendFrame(-1, 0, 0, (LINES / 2 + 1) * LC + 2);
    step(0, 0, 1, 0, $urandom);
    check("nrst_locked", 64'(o_locked), 64'd0);
    check("nrst_frames", 64'(o_frameCount), 64'd1);
    idleCycles(1);
    sendFrame(-1, 0, 0, -1);
    check("nrst_resume", 64'(o_frameCount), 64'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hdp_receiver.md
HDP_RECEIVER -- requirements
Module: hdp_receiver

Interface
REQ-001 SHALL have parameter PACKETS_PER_LINE, default 40, meaning valid 32-bit packets per line.
REQ-002 SHALL have parameter LINE_CLOCKS, default 44, meaning total clocks per line including line blanking.
REQ-003 SHALL have parameter LINES, default 1280, meaning lines per frame.
REQ-004 SHALL have parameter BACK_PORCH, default 24, meaning blank clocks after the last line.
REQ-005 SHALL have parameter UPDATE_PACKETS, default 28, meaning the number of clocks from frame start for which update is high.
REQ-006 SHALL have port i_clock, input, 1 bit: the only clock. One clock; reset is synchronous and active-high.
REQ-007 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port i_nReset, input, 1 bit: panel reset from the transmitter; low forces IDLE.
REQ-009 SHALL have ports i_lcdData (input, 32 bits), i_valid (input, 1 bit) and i_update (input, 1 bit): the HDP data, data-valid and frame-update strobe.
REQ-010 SHALL have ports o_pixelData (output, 32 bits) and o_pixelValid (output, 1 bit): the accepted packet and its strobe.
REQ-011 SHALL have ports o_packetIndex (output, 6 bits) and o_lineIndex (output, 11 bits): the position of the accepted packet.
REQ-012 SHALL have ports o_frameStart and o_frameDone (outputs, 1 bit each): single-cycle pulses.
REQ-013 SHALL have ports o_error (output, 1 bit, single-cycle pulse) and o_locked (output, 1 bit, level).
REQ-014 SHALL have ports o_frameCount (output, 16 bits), o_errorCount (output, 8 bits) and o_checksum (output, 32 bits).

Function
REQ-015 SHALL sample all HDP inputs on the rising edge of i_clock, because the transmitter drives them on the falling edge.
REQ-016 SHALL define frame clock k = line*LINE_CLOCKS + p, where p is 0..LINE_CLOCKS-1, the frame ends at k = LINES*LINE_CLOCKS+BACK_PORCH-1, and the default total is 56344 clocks.
REQ-017 SHALL expect valid = (k < LINES*LINE_CLOCKS) && (p < PACKETS_PER_LINE) and update = (k < UPDATE_PACKETS).
REQ-018 SHALL implement the states IDLE, SEEK, ACTIVE and PORCH.
REQ-019 SHALL go from IDLE to SEEK when i_nReset is high, and from any state to IDLE within 1 cycle when i_nReset is low.
REQ-020 SHALL, in SEEK, detect frame start as i_update=1, i_valid=1 and the previous sample of i_update=0; that cycle is k=0 and the state becomes ACTIVE.
REQ-021 SHALL, in ACTIVE, register an accepted packet to o_pixelData/o_pixelValid with o_packetIndex=p and o_lineIndex=line, one cycle after sampling (latency 1).
REQ-022 SHALL assert o_frameStart together with the o_pixelValid of packet (0,0).
REQ-023 SHALL enter PORCH after k = LINES*LINE_CLOCKS-1, and on the last porch clock pulse o_frameDone and return to ACTIVE expecting k=0 on the very next clock, with no SEEK between frames.
REQ-024 SHALL, on any mismatch between sampled and expected valid/update: pulse o_error, not forward the packet, drop o_locked, not pulse o_frameDone, and go to SEEK.
REQ-025 SHALL require i_update to be high at k=0 of a back-to-back frame; if it is absent, that is a mismatch per REQ-024.
REQ-026 SHALL set o_locked to 1 on the first o_frameDone and clear it on error or IDLE.
REQ-027 SHALL increment o_frameCount on each o_frameDone, wrapping 65535→0.
REQ-028 SHALL increment o_errorCount on each o_error, saturating at 255.
REQ-029 SHALL ignore i_lcdData when the expected valid is 0 (blanking content is don't-care).

Reset
REQ-030 SHALL, on i_reset: enter IDLE and clear every output to 0, including counters and checksum. i_reset has priority over all other inputs.
REQ-031 SHALL, on i_nReset low: clear k and o_locked, and preserve o_frameCount, o_errorCount and o_checksum.

Configuration
REQ-032 SHALL, with HDP_RECEIVER_CHECKSUM_EN defined: accumulate a modulo-2^32 sum of accepted packets per frame, load it into o_checksum on o_frameDone, and clear the accumulator at o_frameStart.
REQ-033 SHALL, without HDP_RECEIVER_CHECKSUM_EN: tie o_checksum to 0 and synthesise no accumulator.

Structure
REQ-034 SHALL place the default timing constants, the state enumeration and the expected-strobe computation widths in the shared package hdp_pkg.
REQ-035 SHALL implement the k/p/line position counter as sub-module hdp_timing_counter (inputs: clear and advance; outputs: p, line, porch flag and frame-end flag).

Verification
REQ-036 SHALL cover a clean frame: a default-timed frame from a transmitter model gives 51200 o_pixelValid pulses, o_frameDone at clock 56344 after start, o_frameCount=1 and o_locked=1.
REQ-037 SHALL cover back-to-back frames: 3 frames with no gap give o_frameCount=3, o_errorCount=0 and exactly 3 o_frameStart pulses.
REQ-038 SHALL cover a valid glitch: i_valid held high at line 5, p=41 gives o_error at the next clock, o_locked=0, no o_frameDone, and relock only on the following frame start.
REQ-039 SHALL cover a missing update: i_update low at k=0 of frame 2 gives o_error, o_errorCount=1 and a state of SEEK.
REQ-040 SHALL cover checksum: with HDP_RECEIVER_CHECKSUM_EN and all packets 32'h00000001, o_checksum=51200 after the frame; without the macro, o_checksum=0.
REQ-041 SHALL cover reset mid-frame: i_reset at line 600 clears all outputs; i_nReset low at line 600 instead gives IDLE and o_frameCount retained.
